fwd_bypass_net: RTL and testbench
=================================

Name: fwd_bypass_net

Overview:
- Parametrised operand-forwarding network; the successor to the fixed 3-input forwarding select.
- Keeps a shift-register history of the last DEPTH architectural register writes.
- For each of NREAD source operands, selects the youngest matching in-flight result, or else the register-file value.
- Sits between the decode/register-read stage and the execute stage.

Parameters:
XLEN, 32, data width of operands and results
DEPTH, 3, number of retired-write history entries tracked (>=1)
NREAD, 2, number of source-operand read ports (>=1)
AW, 5, register address width
SW, $clog2(DEPTH+2), width of each per-port source code (derived; not overridable)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_stall  input  1  hold the history; no shift
i_flush  input  1  invalidate all history entries
i_wr_en  input  1  result write valid this cycle
i_wr_rd  input  AW  destination register of the write
i_wr_data  input  XLEN  result data
i_rs_addr  input  NREAD*AW  source register addresses; port p at [p*AW +: AW]
i_rf_data  input  NREAD*XLEN  register-file read data per port
o_opnd  output  NREAD*XLEN  forwarded operand per port
o_fwd_hit  output  NREAD  1 = operand taken from the live write or the history, not the register file
o_fwd_src  output  NREAD*SW  0 = register file, 1 = live write port, k+2 = history entry k
o_hist_valid  output  DEPTH  valid bit of each history entry; entry 0 is youngest

Behaviour:
- Clock and reset: one clock, i_clk. i_rst_n is asynchronous, active-low.
- Reset values: all history valid bits 0; history rd and data fields 0; o_hist_valid = 0.
  - After reset, o_opnd equals i_rf_data; o_fwd_hit = 0; o_fwd_src = 0.
- History update at the rising edge, evaluated in priority order:
  1. i_flush=1: all valid bits cleared. The live write of that cycle is also discarded. Flush overrides stall.
  2. i_stall=1: history holds unchanged.
  3. Otherwise: entry k+1 <= entry k for k = 0..DEPTH-2; entry DEPTH-1 is dropped.
     - entry 0 <= {valid = i_wr_en && (i_wr_rd != 0), rd = i_wr_rd, data = i_wr_data}.
     - An entry with valid=0 still shifts; its data content is don't-care.
- Operand select: purely combinational from current inputs and history; zero-cycle latency. Ports are evaluated independently and identically.
  - rs == 0 (x0): o_opnd = i_rf_data slice, hit = 0, src = 0. Never forwarded.
  - Else if i_wr_en && i_wr_rd == rs: live write data, src = 1.
  - Else: the lowest-index history entry k with valid && rd == rs, src = k+2.
  - Else: i_rf_data slice, src = 0.
  - Youngest match always wins; older duplicate entries for the same register are shadowed.
  - The live-write match applies even when i_stall or i_flush is asserted in the same cycle.
- o_fwd_hit = (o_fwd_src != 0).
- Writes with i_wr_rd = 0 are never recorded and never matched.
- Reset asserted mid-operation: history cleared immediately (asynchronously). Combinational outputs then follow the register-file and live-write path only.
- DEPTH=1: history has a single entry; there is no shift chain.
- No combinational path from o_* back to any input.

Test Plan:
1. Reset, then rs0=5, rs1=7, rf data 0x11/0x22, no writes -> o_opnd = 0x11/0x22, hit = 00, src = 0/0, o_hist_valid = 000.
2. Write rd=5 data 0xA5A5A5A5 with rs0=5 the same cycle -> o_opnd0 = 0xA5A5A5A5, src0 = 1. Next cycle, no write -> src0 = 2, same data. Two idle cycles later -> src0 = 4. One more cycle -> src0 = 0, rf data returned.
3. Write rd=3 0x1 in cycle N and rd=3 0x2 in cycle N+1, then rs1=3 in cycle N+2 -> o_opnd1 = 0x2, src1 = 2 (youngest wins over entry 1).
4. Write rd=0 data 0xFFFFFFFF, then rs0=0 with rf data 0 -> o_opnd0 = 0, hit0 = 0; history entry 0 valid = 0.
5. Load rd=9 into the history, hold i_stall for 3 cycles -> src stays 2 throughout, o_hist_valid = 001. Release stall -> src = 3 on the next cycle.
6. Fill the history with rd=4, rd=6, rd=8, then pulse i_flush with i_stall=1 and i_wr_en=1 rd=4 -> live match src = 1 during the flush cycle. Next cycle o_hist_valid = 000 and all reads return rf data. Assert i_rst_n low mid-run -> o_hist_valid = 000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fwd_bypass_net.sv
// Operand-forwarding network: tracks the last DEPTH register writes and, for
// each read port, returns the youngest in-flight value for the source register
// (live write first, then history entry 0..DEPTH-1) or the register-file value.
module fwd_bypass_net #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic                    i_wr_en,
  input  logic [AW-1:0]           i_wr_rd,
  input  logic [XLEN-1:0]         i_wr_data,
  input  logic [NREAD*AW-1:0]     i_rs_addr,
  input  logic [NREAD*XLEN-1:0]   i_rf_data,
  output logic [NREAD*XLEN-1:0]   o_opnd,
  output logic [NREAD-1:0]        o_fwd_hit,
  output logic [NREAD*$clog2(DEPTH+2)-1:0] o_fwd_src,
  output logic [DEPTH-1:0]        o_hist_valid
);

  localparam int unsigned SW = $clog2(DEPTH + 2);

  // One retired-write record; entry 0 of the history is the youngest.
  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } hist_t;

  hist_t [DEPTH-1:0] hist_q;
  hist_t [DEPTH-1:0] hist_d;

  // Next history: flush clears valids, stall holds, otherwise shift in the live write.
  always_comb begin
    hist_d = hist_q;
    if (i_flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        hist_d[k].valid = 1'b0;
      end
    end else if (!i_stall) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        hist_d[k] = hist_q[k-1];
      end
      hist_d[0].valid = i_wr_en && (i_wr_rd != '0);
      hist_d[0].rd    = i_wr_rd;
      hist_d[0].data  = i_wr_data;
    end
  end

  // History register with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Export per-entry valid bits.
  always_comb begin
    o_hist_valid = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_hist_valid[k] = hist_q[k].valid;
    end
  end

  // Per-port operand select; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    logic [AW-1:0]   rs;
    logic [XLEN-1:0] opnd;
    logic [SW-1:0]   src;
    o_opnd    = '0;
    o_fwd_hit = '0;
    o_fwd_src = '0;
    rs        = '0;
    opnd      = '0;
    src       = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      rs   = i_rs_addr[p*AW +: AW];
      opnd = i_rf_data[p*XLEN +: XLEN];
      src  = '0;
      if (rs != '0) begin
        if (i_wr_en && (i_wr_rd == rs)) begin
          opnd = i_wr_data;
          src  = SW'(1);
        end else begin
          for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (hist_q[k].valid && (hist_q[k].rd == rs)) begin
              opnd = hist_q[k].data;
              src  = SW'(k + 2);
            end
          end
        end
      end
      o_opnd[p*XLEN +: XLEN] = opnd;
      o_fwd_src[p*SW +: SW]  = src;
      o_fwd_hit[p]           = (src != '0);
    end
  end

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Directed bench for fwd_bypass_net with default parameters (XLEN=32, DEPTH=3, NREAD=2).
module tb_fwd_bypass_net;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned NREAD = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned SW    = 3;

  logic                  i_clk;
  logic                  i_rst_n;
  logic                  i_stall;
  logic                  i_flush;
  logic                  i_wr_en;
  logic [AW-1:0]         i_wr_rd;
  logic [XLEN-1:0]       i_wr_data;
  logic [NREAD*AW-1:0]   i_rs_addr;
  logic [NREAD*XLEN-1:0] i_rf_data;
  logic [NREAD*XLEN-1:0] o_opnd;
  logic [NREAD-1:0]      o_fwd_hit;
  logic [NREAD*SW-1:0]   o_fwd_src;
  logic [DEPTH-1:0]      o_hist_valid;

  int n_tests;
  int n_fail;

  fwd_bypass_net #(
    .XLEN (XLEN),
    .DEPTH(DEPTH),
    .NREAD(NREAD),
    .AW   (AW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .i_wr_en     (i_wr_en),
    .i_wr_rd     (i_wr_rd),
    .i_wr_data   (i_wr_data),
    .i_rs_addr   (i_rs_addr),
    .i_rf_data   (i_rf_data),
    .o_opnd      (o_opnd),
    .o_fwd_hit   (o_fwd_hit),
    .o_fwd_src   (o_fwd_src),
    .o_hist_valid(o_hist_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Count a comparison and report a mismatch.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and checks happen mid-cycle.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_rs(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    i_rs_addr = {r1, r0};
  endtask

  task automatic wr(input logic en, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    i_wr_en   = en;
    i_wr_rd   = rd;
    i_wr_data = d;
  endtask

  function automatic logic [XLEN-1:0] op(input int p);
    return o_opnd[p*XLEN +: XLEN];
  endfunction

  function automatic logic [SW-1:0] src(input int p);
    return o_fwd_src[p*SW +: SW];
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_rst_n = 1'b0;
    i_stall = 1'b0;
    i_flush = 1'b0;
    wr(1'b0, '0, '0);
    set_rs(5'd5, 5'd7);
    i_rf_data = {32'h22, 32'h11};

    // 1: reset state
    #1;
    check("rst_hist_valid", 64'(o_hist_valid), 64'h0);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    check("t1_opnd0", 64'(op(0)), 64'h11);
    check("t1_opnd1", 64'(op(1)), 64'h22);
    check("t1_hit", 64'(o_fwd_hit), 64'h0);
    check("t1_src0", 64'(src(0)), 64'h0);
    check("t1_src1", 64'(src(1)), 64'h0);
    check("t1_hist_valid", 64'(o_hist_valid), 64'h0);

    // 2: live write, then ageing through the history
    wr(1'b1, 5'd5, 32'hA5A5A5A5);
    #1;
    check("t2_live_opnd0", 64'(op(0)), 64'hA5A5A5A5);
    check("t2_live_src0", 64'(src(0)), 64'd1);
    check("t2_live_hit", 64'(o_fwd_hit), 64'h1);
    tick();
    wr(1'b0, '0, '0);
    #1;
    check("t2_e0_src0", 64'(src(0)), 64'd2);
    check("t2_e0_opnd0", 64'(op(0)), 64'hA5A5A5A5);
    tick();
    tick();
    #1;
    check("t2_e2_src0", 64'(src(0)), 64'd4);
    check("t2_e2_opnd0", 64'(op(0)), 64'hA5A5A5A5);
    check("t2_e2_hist", 64'(o_hist_valid), 64'h4);
    tick();
    #1;
    check("t2_aged_src0", 64'(src(0)), 64'd0);
    check("t2_aged_opnd0", 64'(op(0)), 64'h11);
    check("t2_aged_hist", 64'(o_hist_valid), 64'h0);

    // 3: youngest duplicate wins
    set_rs(5'd1, 5'd3);
    wr(1'b1, 5'd3, 32'h1);
    tick();
    wr(1'b1, 5'd3, 32'h2);
    #1;
    check("t3_live_over_e0", 64'(op(1)), 64'h2);
    check("t3_live_src1", 64'(src(1)), 64'd1);
    tick();
    wr(1'b0, '0, '0);
    #1;
    check("t3_opnd1", 64'(op(1)), 64'h2);
    check("t3_src1", 64'(src(1)), 64'd2);
    check("t3_hist", 64'(o_hist_valid), 64'h3);

    // 4: x0 never recorded nor forwarded
    set_rs(5'd0, 5'd3);
    i_rf_data = {32'h22, 32'h0};
    wr(1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    check("t4_x0_opnd0", 64'(op(0)), 64'h0);
    check("t4_x0_hit", 64'(o_fwd_hit), 64'h2);
    tick();
    wr(1'b0, '0, '0);
    #1;
    check("t4_hist", 64'(o_hist_valid), 64'h6);
    check("t4_src1", 64'(src(1)), 64'd3);
    check("t4_opnd1", 64'(op(1)), 64'h2);

    // 5: stall holds history
    i_rf_data = {32'h22, 32'h11};
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    set_rs(5'd9, 5'd7);
    wr(1'b1, 5'd9, 32'h99);
    tick();
    wr(1'b0, '0, '0);
    i_stall = 1'b1;
    #1;
    check("t5_src0_pre", 64'(src(0)), 64'd2);
    check("t5_hist_pre", 64'(o_hist_valid), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("t5_stall_src0", 64'(src(0)), 64'd2);
      check("t5_stall_hist", 64'(o_hist_valid), 64'h1);
      check("t5_stall_opnd0", 64'(op(0)), 64'h99);
    end
    i_stall = 1'b0;
    tick();
    #1;
    check("t5_release_src0", 64'(src(0)), 64'd3);
    check("t5_release_hist", 64'(o_hist_valid), 64'h2);

    // 6: flush overrides stall; live match still visible
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    wr(1'b1, 5'd4, 32'h44);
    tick();
    wr(1'b1, 5'd6, 32'h66);
    tick();
    wr(1'b1, 5'd8, 32'h88);
    tick();
    wr(1'b0, '0, '0);
    set_rs(5'd4, 5'd6);
    #1;
    check("t6_fill_hist", 64'(o_hist_valid), 64'h7);
    check("t6_fill_src0", 64'(src(0)), 64'd4);
    check("t6_fill_opnd0", 64'(op(0)), 64'h44);
    check("t6_fill_src1", 64'(src(1)), 64'd3);
    i_flush = 1'b1;
    i_stall = 1'b1;
    wr(1'b1, 5'd4, 32'h4444);
    #1;
    check("t6_flush_live_src0", 64'(src(0)), 64'd1);
    check("t6_flush_live_opnd0", 64'(op(0)), 64'h4444);
    check("t6_flush_src1", 64'(src(1)), 64'd3);
    tick();
    i_flush = 1'b0;
    i_stall = 1'b0;
    wr(1'b0, '0, '0);
    #1;
    check("t6_post_hist", 64'(o_hist_valid), 64'h0);
    check("t6_post_opnd0", 64'(op(0)), 64'h11);
    check("t6_post_opnd1", 64'(op(1)), 64'h22);
    check("t6_post_src", 64'(o_fwd_src), 64'h0);

    // asynchronous reset mid-run
    wr(1'b1, 5'd4, 32'h55);
    tick();
    wr(1'b0, '0, '0);
    #1;
    check("t6_reload_hist", 64'(o_hist_valid), 64'h1);
    i_rst_n = 1'b0;
    #1;
    check("t6_arst_hist", 64'(o_hist_valid), 64'h0);
    check("t6_arst_opnd0", 64'(op(0)), 64'h11);
    wr(1'b1, 5'd4, 32'h77);
    #1;
    check("t6_arst_live_src0", 64'(src(0)), 64'd1);
    check("t6_arst_live_opnd0", 64'(op(0)), 64'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
